sram_responder: RTL and testbench

- Responder end of the SP SRAM port. Answers the controller's EN/WE/ADDR/DI requests with registered read data on sram_DO.
- Owns the word-addressed memory array.
- Includes an image-loader port, so a test harness or boot logic can stream a program image into memory while the processor is idle.
- Sits between the CTL block and the storage, in place of a bare behavioural memory.

---
 rtl/sram_responder_pkg.sv | 17 +
 rtl/sram_array.sv | 42 ++++
 rtl/sram_responder.sv | 143 ++++++++++++++
 tb/tb_sram_responder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_responder_pkg.sv
// rtl/sram_responder_pkg.sv - shared constants for the SRAM responder and its CTL peer
// Purpose: default port geometry, FSM state encodings and an index-width helper.
package sram_responder_pkg;

    localparam int SRAM_RESP_ADDR_W = 16;
    localparam int SRAM_RESP_DATA_W = 32;
    localparam int SRAM_RESP_DEPTH  = 65536;

    localparam logic [0:0] SRAM_RESP_STATE_IDLE = 1'b0;
    localparam logic [0:0] SRAM_RESP_STATE_LOAD = 1'b1;

    // Bits needed to index DEPTH words; at least one so a 1-word array still has a port.
    function automatic int sram_idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - word storage with one write port and one registered read port
// Purpose: the memory array itself; the storage is never reset.
// Ports:
//   clk, reset        clock, async active-high reset (read register only)
//   we, waddr, wdata  write port, commits on the rising edge
//   re, raddr, rzero  read request; rzero forces the registered result to 0
//   rdata             registered read data, holds between reads
module sram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 65536,
    parameter int IDX_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    input  logic              rzero,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rzero lets the caller return 0 for addresses it has judged out of range
    // without ever indexing past the end of the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - responder end of the SP SRAM port with an image-loader port
// Purpose: serves EN/WE/ADDR/DI requests with 1-cycle registered read data, and in
//   LOAD state streams ld_data words into consecutive addresses from 0.
// Ports:
//   clk, reset                       clock, async active-high reset
//   sram_EN/WE/ADDR/DI, sram_DO      processor port
//   ld_start/valid/last/data         loader input; ld_ready, ld_done, busy status
//   oor_err                          sticky out-of-range access flag
// Optional (SRAM_RESPONDER_STATS_EN): stats_clr in, rd_count/wr_count out (saturating).
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int ADDR_W = SRAM_RESP_ADDR_W,
    parameter int DATA_W = SRAM_RESP_DATA_W,
    parameter int DEPTH  = SRAM_RESP_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sram_EN,
    input  logic              sram_WE,
    input  logic [ADDR_W-1:0] sram_ADDR,
    input  logic [DATA_W-1:0] sram_DI,
    output logic [DATA_W-1:0] sram_DO,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic              ld_last,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy,
    output logic              oor_err
`ifdef SRAM_RESPONDER_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    localparam int IDX_W = sram_idx_bits(DEPTH);
    // One extra bit so DEPTH itself is representable (e.g. 65536 with a 16-bit address).
    localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] ld_cnt;
    logic             idle;
    logic             in_range;
    logic             proc_rd;
    logic             proc_wr;
    logic             arr_we;
    logic [IDX_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;

    assign idle     = (state == SRAM_RESP_STATE_IDLE);
    assign in_range = ({1'b0, sram_ADDR} < DEPTH_LIM);
    assign proc_rd  = idle && sram_EN && !sram_WE;
    assign proc_wr  = idle && sram_EN && sram_WE;
    assign busy     = !idle;
    assign ld_ready = !idle;

    // The single write port belongs to the loader in LOAD and to the processor in IDLE.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = sram_ADDR[IDX_W-1:0];
        arr_wdata = sram_DI;
        if (!idle) begin
            arr_we    = ld_valid;
            arr_waddr = ld_cnt;
            arr_wdata = ld_data;
        end else if (proc_wr && in_range) begin
            arr_we = 1'b1;
        end
    end

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (proc_rd),
        .raddr (sram_ADDR[IDX_W-1:0]),
        .rzero (!in_range),
        .rdata (sram_DO)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SRAM_RESP_STATE_IDLE;
            ld_cnt  <= '0;
            ld_done <= 1'b0;
            oor_err <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                SRAM_RESP_STATE_IDLE: begin
                    if (sram_EN && !in_range) begin
                        oor_err <= 1'b1;
                    end
                    if (ld_start) begin
                        state  <= SRAM_RESP_STATE_LOAD;
                        ld_cnt <= '0;
                    end
                end
                default: begin
                    if (ld_valid) begin
                        ld_cnt <= ld_cnt + 1'b1;
                        // The last array word ends the load even without ld_last.
                        if (ld_last || (ld_cnt == LAST_IDX)) begin
                            state   <= SRAM_RESP_STATE_IDLE;
                            ld_done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef SRAM_RESPONDER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (stats_clr) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (proc_rd && (rd_count != 32'hFFFF_FFFF)) begin
                rd_count <= rd_count + 32'd1;
            end
            if (proc_wr && (wr_count != 32'hFFFF_FFFF)) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - self-checking bench for sram_responder (DEPTH = 16)
module tb_sram_responder;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sram_EN = 1'b0;
    logic              sram_WE = 1'b0;
    logic [ADDR_W-1:0] sram_ADDR = '0;
    logic [DATA_W-1:0] sram_DI = '0;
    logic [DATA_W-1:0] sram_DO;
    logic              ld_start = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_last = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_ready;
    logic              ld_done;
    logic              busy;
    logic              oor_err;
`ifdef SRAM_RESPONDER_STATS_EN
    logic              stats_clr = 1'b0;
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;
`endif

    sram_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sram_EN   (sram_EN),
        .sram_WE   (sram_WE),
        .sram_ADDR (sram_ADDR),
        .sram_DI   (sram_DI),
        .sram_DO   (sram_DO),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_last   (ld_last),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .busy      (busy),
        .oor_err   (oor_err)
`ifdef SRAM_RESPONDER_STATS_EN
        ,
        .stats_clr (stats_clr),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents, last read result, sticky error, access counts.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_do  = '0;
    logic        ref_oor = 1'b0;
    int unsigned ref_rd  = 0;
    int unsigned ref_wr  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string tag);
`ifdef SRAM_RESPONDER_STATS_EN
        chk({tag, "_rd_count"}, rd_count, ref_rd);
        chk({tag, "_wr_count"}, wr_count, ref_wr);
`else
        if (tag.len() == 0) $display("stats disabled");
`endif
    endtask

    // One processor access in IDLE, checked against the model after the edge.
    task automatic proc_op(input bit we, input int addr, input logic [31:0] data);
        sram_EN   = 1'b1;
        sram_WE   = we;
        sram_ADDR = addr[ADDR_W-1:0];
        sram_DI   = data;
        step();
        sram_EN = 1'b0;
        sram_WE = 1'b0;
        if (we) begin
            ref_wr++;
            if (addr < DEPTH) ref_mem[addr] = data;
            else ref_oor = 1'b1;
        end else begin
            ref_rd++;
            if (addr < DEPTH) ref_do = ref_mem[addr];
            else begin
                ref_do  = '0;
                ref_oor = 1'b1;
            end
        end
        chk(we ? "wr_do_hold" : "rd_do", sram_DO, ref_do);
        chk("oor_err", {31'b0, oor_err}, {31'b0, ref_oor});
    endtask

    // Image load of up to n words; fixed data gives 0x11, 0x22, ...; noisy adds
    // idle loader cycles carrying stray ld_start and processor requests.
    task automatic do_load(input int n, input bit use_last, input bit fixed, input bit noisy);
        int a;
        bit term;
        logic [31:0] d;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("load_busy", {31'b0, busy}, 32'd1);
        chk("load_ready", {31'b0, ld_ready}, 32'd1);
        a = 0;
        term = 1'b0;
        while (!term) begin
            if (noisy) begin
                repeat ($urandom_range(0, 2)) begin
                    ld_valid  = 1'b0;
                    ld_start  = 1'($urandom_range(0, 1));
                    sram_EN   = 1'b1;
                    sram_WE   = 1'($urandom_range(0, 1));
                    sram_ADDR = ADDR_W'($urandom_range(0, DEPTH - 1));
                    sram_DI   = $urandom;
                    step();
                    chk("gap_done", {31'b0, ld_done}, 32'd0);
                    chk("gap_busy", {31'b0, busy}, 32'd1);
                    chk("gap_do_hold", sram_DO, ref_do);
                end
                ld_start = 1'b0;
                sram_EN  = 1'b0;
                sram_WE  = 1'b0;
            end
            d = fixed ? 32'h11 * (a + 1) : $urandom;
            ld_valid = 1'b1;
            ld_data  = d;
            ld_last  = use_last && (a == n - 1);
            step();
            ref_mem[a] = d;
            a++;
            term = ld_last || (a == DEPTH);
            chk("word_done", {31'b0, ld_done}, {31'b0, term});
            chk("word_busy", {31'b0, busy}, {31'b0, !term});
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        step();
        chk("done_pulse_end", {31'b0, ld_done}, 32'd0);
        chk("ready_after", {31'b0, ld_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int addr;
        bit we;
        // Reset state
        step();
        step();
        chk("rst_do", sram_DO, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, ld_ready}, 32'd0);
        chk("rst_done", {31'b0, ld_done}, 32'd0);
        chk("rst_oor", {31'b0, oor_err}, 32'd0);
        chk_stats("rst");
        reset = 1'b0;
        step();

        // Directed: 4-word image with ld_last on the 4th
        do_load(4, 1'b1, 1'b1, 1'b0);
        proc_op(1'b0, 2, 32'h0);
        chk("rd2_val", sram_DO, 32'h33);
        step();
        step();
        chk("rd2_hold", sram_DO, 32'h33);
        proc_op(1'b0, 0, 32'h0);
        proc_op(1'b0, 3, 32'h0);
        proc_op(1'b1, 5, 32'hDEAD_BEEF);
        proc_op(1'b0, 5, 32'h0);
        chk("rd5_val", sram_DO, 32'hDEAD_BEEF);
        chk_stats("early");

        // Give every word a known value before random traffic
        for (int i = 0; i < DEPTH; i++) proc_op(1'b1, i, $urandom);

        // Out of range: read returns 0, write dropped (no aliasing onto 20 mod 16)
        proc_op(1'b1, 4, 32'h0404_0404);
        proc_op(1'b0, 20, 32'h0);
        chk("oor_rd_zero", sram_DO, 32'd0);
        chk("oor_set", {31'b0, oor_err}, 32'd1);
        proc_op(1'b1, 20, 32'h1234_5678);
        proc_op(1'b0, 4, 32'h0);
        chk("oor_no_alias", sram_DO, 32'h0404_0404);
        chk("oor_sticky", {31'b0, oor_err}, 32'd1);

        // Processor write during LOAD is ignored
        ld_start = 1'b1;
        step();
        ld_start  = 1'b0;
        ld_valid  = 1'b1;
        ld_data   = 32'hA5A5_0000;
        sram_EN   = 1'b1;
        sram_WE   = 1'b1;
        sram_ADDR = '0;
        sram_DI   = 32'h0000_FFFF;
        step();
        ref_mem[0] = 32'hA5A5_0000;
        ld_valid = 1'b0;
        sram_WE  = 1'b0;
        step();
        chk("load_rd_ignored", sram_DO, ref_do);
        sram_EN  = 1'b0;
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        ld_data  = 32'hA5A5_0001;
        step();
        ref_mem[1] = 32'hA5A5_0001;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("load2_done", {31'b0, ld_done}, 32'd1);
        proc_op(1'b0, 0, 32'h0);
        chk("load_wr_ignored", sram_DO, 32'hA5A5_0000);

        // ld_valid in IDLE must not write
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            step();
        end
        ld_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) proc_op(1'b0, i, 32'h0);

        // Auto-terminate at the last word, then randomized loads with noise
        do_load(DEPTH, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_load($urandom_range(1, DEPTH), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) proc_op(1'b0, i, 32'h0);

        // Randomized processor traffic
        for (int i = 0; i < 150; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH, 255)
                                               : $urandom_range(0, DEPTH - 1);
            proc_op(we, addr, $urandom);
        end
        chk_stats("random");

        // Reset in the middle of a load
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'h5500 + i;
            step();
            ref_mem[i] = 32'h5500 + i;
        end
        ld_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, ld_done}, 32'd0);
        chk("abort_do", sram_DO, 32'd0);
        chk("abort_oor", {31'b0, oor_err}, 32'd0);
        ref_do  = '0;
        ref_oor = 1'b0;
        ref_rd  = 0;
        ref_wr  = 0;
        chk_stats("abort");
        step();
        reset = 1'b0;
        step();
        chk("abort_no_done", {31'b0, ld_done}, 32'd0);
        for (int i = 0; i < DEPTH; i++) proc_op(1'b0, i, 32'h0);

`ifdef SRAM_RESPONDER_STATS_EN
        // Counters: clear, 3 reads + 2 writes, clear overriding a same-cycle read
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        ref_rd = 0;
        ref_wr = 0;
        chk_stats("clr");
        proc_op(1'b0, 1, 32'h0);
        proc_op(1'b1, 30, 32'h9);
        proc_op(1'b0, 40, 32'h0);
        proc_op(1'b1, 7, 32'h77);
        proc_op(1'b0, 7, 32'h0);
        chk("stats_rd3", rd_count, 32'd3);
        chk("stats_wr2", wr_count, 32'd2);
        stats_clr = 1'b1;
        sram_EN   = 1'b1;
        sram_ADDR = 8'd7;
        step();
        stats_clr = 1'b0;
        sram_EN   = 1'b0;
        chk("clr_over_rd", rd_count, 32'd0);
        chk("clr_over_wr", wr_count, 32'd0);
        chk("clr_rd_data", sram_DO, 32'h77);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
